// File: rtl/serv_membuf.sv
// Second buffer register: holds shift amount, store data and load data for one
// instruction, W bits per cycle, with lane replication, load alignment and shift counting.
module serv_membuf #(
    parameter int W  = 1,
    parameter int LB = (W == 1) ? 1 : $clog2(W)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_init,
    input  logic          i_cnt_done,
    input  logic          i_op_b_sel,
    input  logic [W-1:0]  i_rs2,
    input  logic [W-1:0]  i_imm,
    output logic [W-1:0]  o_op_b,
    input  logic          i_shift_op,
    input  logic          i_right_shift,
    input  logic          i_mem_op,
    input  logic [1:0]    i_size,
    input  logic          i_signed,
    input  logic [1:0]    i_lsb,
    input  logic          i_load,
    input  logic [31:0]   i_dat,
    output logic [31:0]   o_dat,
    output logic [3:0]    o_sel,
    output logic [W-1:0]  o_q,
    output logic [LB-1:0] o_shift_rem,
    output logic          o_sh_done,
    output logic          o_sh_done_r
);

    logic [31:0]   r_dat;
    logic [5:0]    r_bitcnt;
    logic          r_sgn;
    logic          r_first;

    logic [W-1:0]  w_op_b;
    logic [31:0]   w_dat_init;
    logic [31:0]   w_dat_load;
    logic          w_sgn_load;
    logic          w_cnt_mode;
    logic          w_hold;
    logic [5:0]    w_cnt_next;
    logic          w_emit;
    logic [6:0]    w_bitcnt_sum;
    logic [5:0]    w_bitcnt_next;
    logic [6:0]    w_size_bits;
    logic [LB-1:0] w_shift_rem;

    assign w_op_b = i_op_b_sel ? i_rs2 : i_imm;
    assign o_op_b = w_op_b;

    // At W=1 every amount is divisible by W, so the remainder is always zero.
    generate
        if (W == 1) begin : g_rem_w1
            assign w_shift_rem = '0;
        end else begin : g_rem_wn
            assign w_shift_rem = r_dat[LB-1:0];
        end
    endgenerate
    assign o_shift_rem = w_shift_rem;

    always_comb begin
        w_dat_init = {w_op_b, r_dat[31:W]};
        // Only shamt[4:0] is a valid shift amount; bit 5 is the counter's wrap flag.
        if (i_shift_op && i_cnt_done) begin
            w_dat_init[5] = 1'b0;
        end
    end

    assign w_dat_load = i_dat >> {i_lsb, 3'b000};

    always_comb begin
        w_sgn_load = 1'b0;
        case (i_size)
            2'b00:   w_sgn_load = i_dat[{i_lsb, 3'b111}];
            2'b01:   w_sgn_load = i_dat[{i_lsb[1], 4'b1111}];
            default: w_sgn_load = 1'b0;
        endcase
    end

    // A right shift by a non-multiple of W spends one cycle moving the remainder.
    assign w_cnt_mode = i_shift_op & ~i_init;
    assign w_hold     = i_right_shift & r_first & (w_shift_rem != '0);
    assign w_cnt_next = w_hold ? r_dat[5:0] : (r_dat[5:0] - 6'(W));
    assign o_sh_done  = w_cnt_mode & w_cnt_next[5];
    assign o_sh_done_r = r_dat[5];

    assign w_emit        = i_en & ~i_init & i_mem_op & ~i_shift_op;
    assign w_bitcnt_sum  = {1'b0, r_bitcnt} + 7'(W);
    assign w_bitcnt_next = (w_bitcnt_sum > 7'd32) ? 6'd32 : w_bitcnt_sum[5:0];

    always_comb begin
        w_size_bits = 7'd32;
        case (i_size)
            2'b00:   w_size_bits = 7'd8;
            2'b01:   w_size_bits = 7'd16;
            default: w_size_bits = 7'd32;
        endcase
    end

    assign o_q = ({1'b0, r_bitcnt} < w_size_bits) ? r_dat[W-1:0] : {W{r_sgn & i_signed}};

    always_comb begin
        o_dat = r_dat;
        o_sel = 4'b1111;
        case (i_size)
            2'b00: begin
                o_dat = {4{r_dat[7:0]}};
                o_sel = 4'b0001 << i_lsb;
            end
            2'b01: begin
                o_dat = {2{r_dat[15:0]}};
                o_sel = i_lsb[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                o_dat = r_dat;
                o_sel = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dat    <= '0;
            r_bitcnt <= '0;
            r_sgn    <= 1'b0;
            r_first  <= 1'b0;
        end else if (i_load) begin
            r_dat    <= w_dat_load;
            r_bitcnt <= '0;
            r_sgn    <= w_sgn_load;
        end else if (i_en && i_init) begin
            r_dat    <= w_dat_init;
            r_first  <= 1'b1;
        end else if (w_cnt_mode) begin
            r_dat[5:0] <= w_cnt_next;
            r_first    <= 1'b0;
        end else if (w_emit) begin
            r_dat    <= r_dat >> W;
            r_bitcnt <= w_bitcnt_next;
        end
    end

endmodule

// File: tb/tb_serv_membuf.sv
// Scoreboard bench for serv_membuf: W=1 and W=4 instances share control inputs;
// stimulus queues expected values per cycle and a negedge monitor compares them.
module tb_serv_membuf;

    localparam int Q1   = 0;
    localparam int Q4   = 1;
    localparam int DAT4 = 2;
    localparam int SEL4 = 3;
    localparam int REM4 = 4;
    localparam int SHD4 = 5;
    localparam int SHR4 = 6;
    localparam int SHD1 = 7;
    localparam int SHR1 = 8;
    localparam int DAT1 = 9;
    localparam int SEL1 = 10;
    localparam int REM1 = 11;
    localparam int OPB4 = 12;
    localparam int OPB1 = 13;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en, init, cnt_done, op_b_sel;
    logic        shift_op, right_shift, mem_op, sgn_in, load;
    logic [1:0]  size, lsb;
    logic [31:0] dat_in;
    logic [0:0]  rs2_1, imm_1, op_b_1, q_1, rem_1;
    logic [3:0]  rs2_4, imm_4, op_b_4, q_4;
    logic [1:0]  rem_4;
    logic [31:0] dat_1, dat_4;
    logic [3:0]  sel_1, sel_4;
    logic        sh_done_1, sh_done_r_1, sh_done_4, sh_done_r_4;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    serv_membuf #(.W(1)) u_w1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
        .i_op_b_sel(op_b_sel), .i_rs2(rs2_1), .i_imm(imm_1), .o_op_b(op_b_1),
        .i_shift_op(shift_op), .i_right_shift(right_shift), .i_mem_op(mem_op),
        .i_size(size), .i_signed(sgn_in), .i_lsb(lsb), .i_load(load), .i_dat(dat_in),
        .o_dat(dat_1), .o_sel(sel_1), .o_q(q_1), .o_shift_rem(rem_1),
        .o_sh_done(sh_done_1), .o_sh_done_r(sh_done_r_1)
    );

    serv_membuf #(.W(4)) u_w4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
        .i_op_b_sel(op_b_sel), .i_rs2(rs2_4), .i_imm(imm_4), .o_op_b(op_b_4),
        .i_shift_op(shift_op), .i_right_shift(right_shift), .i_mem_op(mem_op),
        .i_size(size), .i_signed(sgn_in), .i_lsb(lsb), .i_load(load), .i_dat(dat_in),
        .o_dat(dat_4), .o_sel(sel_4), .o_q(q_4), .o_shift_rem(rem_4),
        .o_sh_done(sh_done_4), .o_sh_done_r(sh_done_r_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            Q1:      return {31'b0, q_1};
            Q4:      return {28'b0, q_4};
            DAT4:    return dat_4;
            SEL4:    return {28'b0, sel_4};
            REM4:    return {30'b0, rem_4};
            SHD4:    return {31'b0, sh_done_4};
            SHR4:    return {31'b0, sh_done_r_4};
            SHD1:    return {31'b0, sh_done_1};
            SHR1:    return {31'b0, sh_done_r_1};
            DAT1:    return dat_1;
            SEL1:    return {28'b0, sel_1};
            REM1:    return {31'b0, rem_1};
            OPB4:    return {28'b0, op_b_4};
            OPB1:    return {31'b0, op_b_1};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: compare every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] a;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s not sampled in its cycle (due %0d, now %0d)", e.name, e.cyc, cyc);
            end else begin
                a = actual(e.sig);
                if (a !== e.exp) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %h expected %h", e.name, cyc, a, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int sig, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = sig;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [1:0] l, input logic [1:0] s,
                           input logic sg);
        mem_op = 1'b1; shift_op = 1'b0; init = 1'b0; en = 1'b0;
        dat_in = d; lsb = l; size = s; sgn_in = sg; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic shift_init4(input logic [31:0] amt, input logic rs);
        logic [31:0] v;
        v = amt;
        mem_op = 1'b0; shift_op = 1'b1; right_shift = rs; op_b_sel = 1'b0;
        init = 1'b1; en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            imm_4 = v[4*k +: 4];
            cnt_done = (k == 7);
            tick();
        end
        init = 1'b0; cnt_done = 1'b0; imm_4 = '0;
    endtask

    initial begin
        logic [31:0] v;
        logic [3:0]  nib;

        rst_n = 1'b0; en = 1'b0; init = 1'b0; cnt_done = 1'b0; op_b_sel = 1'b0;
        shift_op = 1'b0; right_shift = 1'b0; mem_op = 1'b0; sgn_in = 1'b0; load = 1'b0;
        size = 2'b00; lsb = 2'b00; dat_in = '0;
        rs2_1 = '0; imm_1 = '0; rs2_4 = '0; imm_4 = '0;

        tick(); tick();
        chk(Q4, 32'h0, "rst_q");
        chk(SHR4, 32'h0, "rst_sh_done_r");
        chk(REM4, 32'h0, "rst_rem");
        chk(DAT4, 32'h0, "rst_dat");
        chk(SEL4, 32'h1, "rst_sel");
        chk(SEL1, 32'h1, "rst_sel_w1");
        chk(REM1, 32'h0, "rst_rem_w1");
        tick();
        rst_n = 1'b1;
        tick();

        // Half store, W=4
        v = 32'h1234_ABCD;
        op_b_sel = 1'b1; init = 1'b1; en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rs2_4 = v[4*k +: 4];
            if (k == 2) chk(OPB4, {28'b0, v[11:8]}, "op_b_rs2");
            tick();
        end
        init = 1'b0; en = 1'b0; size = 2'b01; lsb = 2'd2;
        chk(DAT4, 32'hABCD_ABCD, "half_dat");
        chk(SEL4, 32'hC, "half_sel");
        tick();
        size = 2'b10; lsb = 2'd0;
        chk(DAT4, 32'h1234_ABCD, "word_dat");
        chk(SEL4, 32'hF, "word_sel");
        tick();
        size = 2'b00; lsb = 2'd3;
        chk(DAT4, 32'hCDCD_CDCD, "byte_dat");
        chk(SEL4, 32'h8, "byte_sel");
        tick();
        size = 2'b01; lsb = 2'd0;
        chk(SEL4, 32'h3, "half_lo_sel");
        tick();

        // Asynchronous reset in the middle of an init pass
        size = 2'b10; lsb = 2'd0; init = 1'b1; en = 1'b1; rs2_4 = 4'hF;
        tick(); tick(); tick();
        chk(DAT4, 32'hFFF1_234A, "pre_rst_dat");
        tick();
        rst_n = 1'b0;
        chk(DAT4, 32'h0, "async_rst_dat");
        chk(Q4, 32'h0, "async_rst_q");
        chk(SHR4, 32'h0, "async_rst_sh_done_r");
        tick();
        rst_n = 1'b1; init = 1'b0; en = 1'b0; rs2_4 = '0;
        tick();

        // Signed byte load, W=1, lane 1
        do_load(32'h0000_8000, 2'd1, 2'b00, 1'b1);
        en = 1'b1;
        v = 32'hFFFF_FF80;
        for (int k = 0; k < 32; k++) begin
            chk(Q1, {31'b0, v[k]}, "ldb_signed_bit");
            tick();
        end
        en = 1'b0;

        do_load(32'h0000_8000, 2'd1, 2'b00, 1'b0);
        en = 1'b1;
        v = 32'h0000_0080;
        for (int k = 0; k < 32; k++) begin
            chk(Q1, {31'b0, v[k]}, "ldb_unsigned_bit");
            tick();
        end
        en = 1'b0;

        // Signed half load, W=4, upper half; run past 16 emits to hit bitcnt saturation
        do_load(32'h8001_0000, 2'd2, 2'b01, 1'b1);
        en = 1'b1;
        v = 32'h0000_8001;
        for (int k = 0; k < 18; k++) begin
            nib = (k < 4) ? v[4*k +: 4] : 4'hF;
            chk(Q4, {28'b0, nib}, "ldh_signed_chunk");
            tick();
        end
        en = 1'b0; mem_op = 1'b0;
        tick();

        // Right shift by 7, W=4: hold cycle then two decrements
        shift_init4(32'd7, 1'b1);
        chk(REM4, 32'd3, "rs7_rem");
        chk(SHD4, 32'd0, "rs7_hold");
        tick();
        chk(SHD4, 32'd0, "rs7_dec1");
        tick();
        chk(SHD4, 32'd1, "rs7_done");
        chk(SHR4, 32'd0, "rs7_done_r_early");
        tick();
        chk(SHR4, 32'd1, "rs7_done_r");
        tick();
        shift_op = 1'b0; en = 1'b0;
        tick();

        // Left shift by 7, W=4: no hold cycle
        shift_init4(32'd7, 1'b0);
        chk(SHD4, 32'd0, "ls7_dec1");
        tick();
        chk(SHD4, 32'd1, "ls7_done");
        tick();
        chk(SHR4, 32'd1, "ls7_done_r");
        tick();
        shift_op = 1'b0; en = 1'b0;
        tick();

        // Right shift by 0, W=4: done on the first count cycle
        shift_init4(32'd0, 1'b1);
        chk(REM4, 32'd0, "s0_rem");
        chk(SHD4, 32'd1, "s0_done");
        tick();
        shift_op = 1'b0; en = 1'b0;
        tick();

        // Shift by 31 at W=1, amount word carries bit 5 which cnt_done must clear
        v = 32'h0000_003F;
        shift_op = 1'b1; right_shift = 1'b0; op_b_sel = 1'b0; init = 1'b1; en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            imm_1 = v[k];
            cnt_done = (k == 31);
            if (k == 5) chk(OPB1, 32'd1, "op_b_imm");
            tick();
        end
        init = 1'b0; cnt_done = 1'b0; imm_1 = '0;
        chk(SHR1, 32'd0, "s31_bit5_cleared");
        chk(SHD1, 32'd0, "s31_count1");
        repeat (30) tick();
        chk(SHD1, 32'd0, "s31_count31");
        tick();
        chk(SHD1, 32'd1, "s31_count32");
        tick();
        chk(SHR1, 32'd1, "s31_done_r");
        tick();
        shift_op = 1'b0; en = 1'b0;
        tick();

        // Load capture beats a simultaneous init shift; misaligned word zero-fills
        op_b_sel = 1'b1; rs2_4 = 4'hF; rs2_1 = 1'b1;
        init = 1'b1; en = 1'b1; mem_op = 1'b0;
        dat_in = 32'hDEAD_BEEF; lsb = 2'd2; size = 2'b10; load = 1'b1;
        tick();
        load = 1'b0; init = 1'b0; en = 1'b0;
        chk(DAT4, 32'h0000_DEAD, "simul_dat_w4");
        chk(Q4, 32'h0000_000D, "simul_q_w4");
        chk(DAT1, 32'h0000_DEAD, "simul_dat_w1");
        tick();

        for (int i = 0; i < 4 && sb.size() > 0; i++) tick();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never sampled (due cycle %0d)", e.name, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
